// File: rtl/xor_gen_pkg.sv
// Shared types, constants and the LFSR step function for the XOR keystream cipher.
// No latency: pure declarations and combinational helper.
// No backpressure: no handshakes live here.
package xor_gen_pkg;

  typedef enum logic [1:0] {
    XOR_STATIC = 2'd0,
    XOR_ROTATE = 2'd1,
    XOR_LFSR   = 2'd2
  } xor_mode_e;

  localparam logic [31:0] XOR_DEF_POLY = 32'h80200003;

  // Widest key/LFSR the shared step function can handle; narrower users zero-extend.
  localparam int XOR_MAX_W = 256;

  // One Galois LFSR step: shift right, fold the polynomial in when the dropped bit is 1.
  function automatic logic [XOR_MAX_W-1:0] lfsr_step(input logic [XOR_MAX_W-1:0] state,
                                                     input logic [XOR_MAX_W-1:0] poly);
    return state[0] ? ((state >> 1) ^ poly) : (state >> 1);
  endfunction

endpackage

// File: rtl/xor_keystream.sv
// Keystream state: key/seed registers, rotating lane index and Galois LFSR.
// ks is combinational from the current state; state updates on the clock edge.
// No backpressure: the parent asserts advance only on an accepted word.
module xor_keystream
  import xor_gen_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              KEY_W     = 32,
  parameter int              MODE      = 0,
  parameter logic [KEY_W-1:0] LFSR_POLY = KEY_W'(XOR_DEF_POLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              advance,
  input  logic              restart,
  output logic [DATA_W-1:0] ks
);

  localparam int NL    = KEY_W / DATA_W;
  localparam int IDX_W = (NL > 1) ? $clog2(NL) : 1;
  localparam xor_mode_e MODE_E = xor_mode_e'(MODE);

  logic [KEY_W-1:0]  key_q;
  logic [KEY_W-1:0]  seed_q;
  logic [KEY_W-1:0]  lfsr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [KEY_W-1:0]  load_val;
  logic [KEY_W-1:0]  lfsr_next;
  logic [DATA_W-1:0] lanes [NL];

  // An all-zero seed would lock the LFSR, so it is replaced by all-ones on load.
  assign load_val  = (key_in == '0) ? '1 : key_in;
  assign lfsr_next = KEY_W'(lfsr_step(XOR_MAX_W'(lfsr_q), XOR_MAX_W'(LFSR_POLY)));

  for (genvar g = 0; g < NL; g++) begin : g_lane
    assign lanes[g] = key_q[g*DATA_W +: DATA_W];
  end

  // State update: reset, then key load, then frame restart, then normal advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= '0;
      seed_q <= '1;
      lfsr_q <= '1;
      idx_q  <= '0;
    end else if (key_load) begin
      key_q  <= key_in;
      seed_q <= load_val;
      lfsr_q <= load_val;
      idx_q  <= '0;
    end else if (restart) begin
      lfsr_q <= seed_q;
      idx_q  <= '0;
    end else if (advance) begin
      lfsr_q <= lfsr_next;
      idx_q  <= (idx_q == IDX_W'(NL - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Keystream word selected by the elaboration-time mode.
  always_comb begin
    ks = '0;
    case (MODE_E)
      XOR_STATIC: ks = key_q[DATA_W-1:0];
      XOR_ROTATE: ks = lanes[idx_q];
      XOR_LFSR:   ks = lfsr_q[DATA_W-1:0];
      default:    ks = '0;
    endcase
  end

endmodule

// File: rtl/xor_stream_cipher.sv
// XOR stream cipher: in_data ^ keystream, with frame restart on in_last and runtime key load.
// Latency 1 cycle through a single output register; 1 word/cycle while out_ready is high.
// Stalls with in_ready low and output held while out_valid && !out_ready.
module xor_stream_cipher
  import xor_gen_pkg::*;
#(
  parameter int               DATA_W    = 8,
  parameter int               KEY_W     = 32,
  parameter int               MODE      = 0,
  parameter logic [KEY_W-1:0] LFSR_POLY = KEY_W'(XOR_DEF_POLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [15:0]       beat_cnt
);

  if (KEY_W < DATA_W || (KEY_W % DATA_W) != 0) begin : g_bad_key_w
    $error("xor_stream_cipher: KEY_W must be a nonzero multiple of DATA_W");
  end
  if (KEY_W > XOR_MAX_W) begin : g_key_too_wide
    $error("xor_stream_cipher: KEY_W exceeds XOR_MAX_W");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("xor_stream_cipher: MODE must be 0, 1 or 2");
  end

  logic              acc;
  logic [DATA_W-1:0] ks;

  // The output register can take a new word when empty or draining this cycle.
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  xor_keystream #(
    .DATA_W    (DATA_W),
    .KEY_W     (KEY_W),
    .MODE      (MODE),
    .LFSR_POLY (LFSR_POLY)
  ) u_ks (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load),
    .key_in   (key_in),
    .advance  (acc),
    .restart  (acc && in_last),
    .ks       (ks)
  );

  // Output register and saturating count of accepted words.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        out_data  <= in_data ^ ks;
        out_last  <= in_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc && beat_cnt != 16'hFFFF) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Directed self-checking bench: three cipher instances (static, rotate, LFSR) on shared stimulus.
module tb_xor_stream_cipher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_load = 1'b0;
  logic [31:0] key_in = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic [7:0]  dat0, dat1, dat2;
  logic        lst0, lst1, lst2;
  logic [15:0] cnt0, cnt1, cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xor_stream_cipher #(.MODE(0)) d0 (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data), .in_last(in_last),
    .out_valid(vld0), .out_ready(out_ready), .out_data(dat0), .out_last(lst0), .beat_cnt(cnt0));

  xor_stream_cipher #(.MODE(1)) d1 (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data), .in_last(in_last),
    .out_valid(vld1), .out_ready(out_ready), .out_data(dat1), .out_last(lst1), .beat_cnt(cnt1));

  xor_stream_cipher #(.MODE(2)) d2 (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data), .in_last(in_last),
    .out_valid(vld2), .out_ready(out_ready), .out_data(dat2), .out_last(lst2), .beat_cnt(cnt2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [31:0] k);
    in_valid = 1'b0;
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (vld1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", vld1); end
    n_checks++;
    if (dat1 !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", dat1); end
    n_checks++;
    if (cnt1 !== 16'h0000) begin n_fail++; $display("FAIL reset_beat_cnt got %h want 0000", cnt1); end
    n_checks++;
    if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", rdy1); end
  endtask

  task automatic test_static();
    load_key(32'h000000FF);
    in_valid = 1'b1; in_data = 8'hB1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (vld0 !== 1'b1 || dat0 !== 8'h4E) begin
      n_fail++; $display("FAIL static_word got vld=%b data=%h want vld=1 data=4e", vld0, dat0);
    end
    n_checks++;
    if (lst0 !== 1'b1) begin n_fail++; $display("FAIL static_last got %b want 1", lst0); end
    tick();
    n_checks++;
    if (vld0 !== 1'b0) begin n_fail++; $display("FAIL static_drain got vld=%b want 0", vld0); end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_a [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA};
    logic [7:0] exp_b [5] = '{8'hAA, 8'hBB, 8'hAA, 8'hBB, 8'hCC};
    load_key(32'hDDCCBBAA);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h00; in_last = 1'b0;
      tick();
      n_checks++;
      if (vld1 !== 1'b1 || dat1 !== exp_a[i]) begin
        n_fail++; $display("FAIL rotate_word%0d got vld=%b data=%h want %h", i, vld1, dat1, exp_a[i]);
      end
    end
    load_key(32'hDDCCBBAA);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h00; in_last = (i == 1);
      tick();
      n_checks++;
      if (vld1 !== 1'b1 || dat1 !== exp_b[i] || lst1 !== (i == 1)) begin
        n_fail++;
        $display("FAIL rotate_last_word%0d got data=%h last=%b want %h last=%b", i, dat1, lst1, exp_b[i], (i == 1));
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
  endtask

  task automatic test_lfsr();
    logic [7:0] exp_w [2] = '{8'h01, 8'h03};
    load_key(32'h00000001);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'h00;
      tick();
      n_checks++;
      if (vld2 !== 1'b1 || dat2 !== exp_w[i]) begin
        n_fail++; $display("FAIL lfsr_word%0d got vld=%b data=%h want %h", i, vld2, dat2, exp_w[i]);
      end
    end
    load_key(32'h00000000);
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (vld2 !== 1'b1 || dat2 !== 8'hFF) begin
      n_fail++; $display("FAIL lfsr_zero_seed got vld=%b data=%h want ff", vld2, dat2);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_key(32'hDDCCBBAA);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    n_checks++;
    if (vld1 !== 1'b1 || dat1 !== 8'hAA) begin
      n_fail++; $display("FAIL bp_first got vld=%b data=%h want aa", vld1, dat1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (rdy1 !== 1'b0 || vld1 !== 1'b1 || dat1 !== 8'hAA) begin
        n_fail++; $display("FAIL bp_hold%0d got rdy=%b vld=%b data=%h want 0 1 aa", i, rdy1, vld1, dat1);
      end
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (vld1 !== 1'b1 || dat1 !== 8'hBB) begin
      n_fail++; $display("FAIL bp_resume0 got vld=%b data=%h want bb", vld1, dat1);
    end
    tick();
    n_checks++;
    if (vld1 !== 1'b1 || dat1 !== 8'hCC) begin
      n_fail++; $display("FAIL bp_resume1 got vld=%b data=%h want cc", vld1, dat1);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (vld1 !== 1'b0) begin n_fail++; $display("FAIL bp_empty got vld=%b want 0", vld1); end
    n_checks++;
    if (cnt1 !== 16'd3) begin n_fail++; $display("FAIL bp_beat_cnt got %0d want 3", cnt1); end
  endtask

  task automatic test_key_collide();
    load_key(32'h04030201);
    in_valid = 1'b1; in_data = 8'h00; key_load = 1'b1; key_in = 32'h40302010;
    tick();
    key_load = 1'b0;
    n_checks++;
    if (dat1 !== 8'h01) begin n_fail++; $display("FAIL collide_old_key got %h want 01", dat1); end
    tick();
    n_checks++;
    if (dat1 !== 8'h10) begin n_fail++; $display("FAIL collide_new_key got %h want 10", dat1); end
    tick();
    n_checks++;
    if (dat1 !== 8'h20) begin n_fail++; $display("FAIL collide_lane1 got %h want 20", dat1); end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (vld1 !== 1'b0 || dat1 !== 8'h00 || cnt1 !== 16'h0000) begin
      n_fail++; $display("FAIL midframe_rst got vld=%b data=%h cnt=%h want 0 00 0000", vld1, dat1, cnt1);
    end
    load_key(32'h04030201);
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (dat1 !== 8'h01) begin n_fail++; $display("FAIL rst_idx_restart got %h want 01", dat1); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    for (int i = 0; i < 65534; i++) tick();
    n_checks++;
    if (cnt1 !== 16'hFFFE) begin n_fail++; $display("FAIL sat_below got %h want fffe", cnt1); end
    tick();
    n_checks++;
    if (cnt1 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h want ffff", cnt1); end
    tick();
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (cnt1 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", cnt1); end
  endtask

  initial begin
    test_reset();
    test_static();
    test_rotate();
    test_lfsr();
    test_back_to_back();
    test_key_collide();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
